// File: rtl/frame_tx_fifo.sv
// Transmit sample FIFO between the frame assembler and the DAC interface.
// Buffers {sop, I, Q} entries, drives a registered almost-full ready, and tracks frames/flags.
module frame_tx_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 64,
    parameter int AFULL_MARGIN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] I_in,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             sop_in,
    output logic             ready_out,
    input  logic             dac_ready,
    output logic             valid_out,
    output logic [WIDTH-1:0] I_out,
    output logic [WIDTH-1:0] Q_out,
    output logic             sop_out,
    output logic [15:0]      frame_count,
    output logic             overflow,
    output logic             underrun,
    input  logic             clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(DEPTH - AFULL_MARGIN);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [EW-1:0] head;

    logic pop;
    logic push;
    logic drop;
    logic xfer;
    logic armed;
    logic underrun_set;

    // A pop is exactly a load of the output register; the FIFO never pops otherwise.
    assign pop  = enable && (count != '0) && (!valid_out || dac_ready);
    assign push = enable && in_valid && ((count < FULL_LEVEL) || pop);
    assign drop = enable && in_valid && (count == FULL_LEVEL) && !pop;
    assign xfer = enable && valid_out && dac_ready;
    assign head = mem[rd_ptr];

    assign underrun_set = armed && enable && dac_ready && !valid_out;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: the sample array carries no reset; entries are only ever read after being written,
    // so resetting them would buy nothing but a large reset fan-out.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {sop_in, I_in, Q_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_out <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_next;
            ready_out <= (count_next < AFULL_LEVEL);
        end
    end

    // Output register: refilled whenever it is empty or being consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            I_out     <= '0;
            Q_out     <= '0;
            sop_out   <= 1'b0;
        end else if (pop) begin
            valid_out <= 1'b1;
            sop_out   <= head[EW-1];
            I_out     <= head[2*WIDTH-1:WIDTH];
            Q_out     <= head[WIDTH-1:0];
        end else if (xfer) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            armed       <= 1'b0;
        end else if (xfer && sop_out) begin
            frame_count <= frame_count + 16'd1;
            armed       <= 1'b1;
        end
    end

    // Sticky flags: a set event in the same cycle takes priority over clr_flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else if (enable) begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
